// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer for the 5-stage MIPS core.
// Detects load-use hazards, sequences branch/jump flushes, freezes the
// pipeline while data memory is busy, and keeps saturating stall/flush counters.
module hazard_controller #(
   parameter int unsigned LOAD_STALLS  = 1,
   parameter int unsigned BRANCH_FLUSH = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs_IF_ID,
   input  logic [4:0]       Rt_IF_ID,
   input  logic             Uses_Rt_ID,
   input  logic [4:0]       Rt_ID_EX,
   input  logic             MemRead_ID_EX,
   input  logic             Branch_Taken_ID,
   input  logic             mem_busy,
   input  logic             perf_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // Extra cycles beyond the first one, which is spent while still in RUN.
   localparam logic [2:0] LU_REM = 3'(LOAD_STALLS - 1);
   localparam logic [2:0] BR_REM = 3'(BRANCH_FLUSH - 1);

   state_t     state, state_next;
   logic [2:0] rem, rem_next;
   logic       lu;

   // Load in EX writes a register the ID instruction reads; $zero never hazards.
   always_comb begin
      lu = MemRead_ID_EX && (Rt_ID_EX != 5'd0) &&
           ((Rt_ID_EX == Rs_IF_ID) || (Uses_Rt_ID && (Rt_ID_EX == Rt_IF_ID)));
   end

   // State and remaining-count register; reset aborts any stall or flush sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         rem   <= '0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
      end
   end

   // Next-state logic: freeze holds everything, otherwise sequence stalls/flushes.
   always_comb begin
      state_next = state;
      rem_next   = rem;
      if (!mem_busy) begin
         unique case (state)
            RUN: begin
               if (lu) begin
                  if (LOAD_STALLS > 1) begin
                     state_next = LU_STALL;
                     rem_next   = LU_REM;
                  end
               end else if (Branch_Taken_ID) begin
                  if (BRANCH_FLUSH > 1) begin
                     state_next = FLUSH;
                     rem_next   = BR_REM;
                  end
               end
            end
            LU_STALL, FLUSH: begin
               rem_next = rem - 3'd1;
               if (rem == 3'd1) begin
                  state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
               rem_next   = '0;
            end
         endcase
      end
   end

   // Mealy outputs: reset, then freeze, then per-state stall/flush/normal.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_hold  = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_hold  = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (lu) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end else if (Branch_Taken_ID) begin
                  if_id_flush  = 1'b1;
               end
            end
            LU_STALL: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end
            FLUSH: begin
               if_id_flush  = 1'b1;
            end
            default: begin
               pc_write     = 1'b1;
            end
         endcase
      end
   end

   // Saturating performance counters; perf_clr overrides any increment.
   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (if_id_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: two instances with different
// parameters, directed vectors with hand-computed per-cycle expectations.
module tb_hazard_controller;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses;
      logic [4:0] rtex;
      logic       mr;
      logic       br;
      logic       busy;
      logic       clr;
   } stim_t;

   typedef struct {
      bit         sel;
      logic [4:0] outs;
      int         st;
      int         fl;
      string      nm;
   } exp_t;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}
   localparam logic [4:0] O_RST  = 5'b00110;
   localparam logic [4:0] O_NORM = 5'b11000;
   localparam logic [4:0] O_STL  = 5'b00010;
   localparam logic [4:0] O_FLS  = 5'b11100;
   localparam logic [4:0] O_FRZ  = 5'b00001;

   logic  clk = 1'b0;
   stim_t in_a, in_b;
   exp_t  q[$];
   int    checks = 0;
   int    errors = 0;

   logic        pw_a, iw_a, fl_a, bb_a, hd_a;
   logic        pw_b, iw_b, fl_b, bb_b, hd_b;
   logic [15:0] sc_a, fc_a;
   logic [3:0]  sc_b, fc_b;

   always #5 clk = ~clk;

   hazard_controller #(.LOAD_STALLS(1), .BRANCH_FLUSH(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(in_a.rst), .Rs_IF_ID(in_a.rs), .Rt_IF_ID(in_a.rt),
      .Uses_Rt_ID(in_a.uses), .Rt_ID_EX(in_a.rtex), .MemRead_ID_EX(in_a.mr),
      .Branch_Taken_ID(in_a.br), .mem_busy(in_a.busy), .perf_clr(in_a.clr),
      .pc_write(pw_a), .if_id_write(iw_a), .if_id_flush(fl_a),
      .id_ex_bubble(bb_a), .ex_mem_hold(hd_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
   );

   hazard_controller #(.LOAD_STALLS(3), .BRANCH_FLUSH(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(in_b.rst), .Rs_IF_ID(in_b.rs), .Rt_IF_ID(in_b.rt),
      .Uses_Rt_ID(in_b.uses), .Rt_ID_EX(in_b.rtex), .MemRead_ID_EX(in_b.mr),
      .Branch_Taken_ID(in_b.br), .mem_busy(in_b.busy), .perf_clr(in_b.clr),
      .pc_write(pw_b), .if_id_write(iw_b), .if_id_flush(fl_b),
      .id_ex_bubble(bb_b), .ex_mem_hold(hd_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
   );

   function automatic stim_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses, input logic [4:0] rtex, input logic mr,
                                input logic br, input logic busy, input logic clr);
      stim_t s;
      s = '{rst, rs, rt, uses, rtex, mr, br, busy, clr};
      return s;
   endfunction

   stim_t IDLE, RSTV, BUSY, BRV, LU5, LUBR;

   // Drive one cycle on the selected instance; the other one idles.
   task automatic step(input bit sel, input stim_t s, input logic [4:0] eo,
                       input int es, input int ef, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      if (sel) begin
         in_b = s;
         in_a = IDLE;
      end else begin
         in_a = s;
         in_b = IDLE;
      end
      e.sel = sel; e.outs = eo; e.st = es; e.fl = ef; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: pops one expectation per cycle and compares mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [4:0] act;
         int as, af;
         e = q.pop_front();
         if (e.sel) begin
            act = {pw_b, iw_b, fl_b, bb_b, hd_b};
            as  = int'(sc_b);
            af  = int'(fc_b);
         end else begin
            act = {pw_a, iw_a, fl_a, bb_a, hd_a};
            as  = int'(sc_a);
            af  = int'(fc_a);
         end
         checks++;
         if (act !== e.outs) begin
            errors++;
            $display("FAIL %s outs: got %b expected %b", e.nm, act, e.outs);
         end
         if (e.st >= 0) begin
            checks++;
            if (as != e.st) begin
               errors++;
               $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, as, e.st);
            end
            checks++;
            if (af != e.fl) begin
               errors++;
               $display("FAIL %s flush_cnt: got %0d expected %0d", e.nm, af, e.fl);
            end
         end
      end
   end

   initial begin
      IDLE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      RSTV = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      BUSY = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      BRV  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
      LU5  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0);
      LUBR = mk(0, 5, 0, 0, 5, 1, 1, 0, 0);
      in_a = RSTV;
      in_b = RSTV;

      // Instance A: LOAD_STALLS=1, BRANCH_FLUSH=1, CNT_W=16
      step(0, RSTV, O_RST, -1, -1, "a_rst0");
      step(0, RSTV, O_RST, 0, 0, "a_rst1");
      step(0, IDLE, O_NORM, 0, 0, "a_after_rst");
      step(0, LU5, O_STL, 0, 0, "a_lu_rs");
      step(0, IDLE, O_NORM, 1, 0, "a_lu_done");
      step(0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), O_NORM, 1, 0, "a_lu_r0");
      step(0, BRV, O_FLS, 1, 0, "a_branch");
      step(0, IDLE, O_NORM, 1, 1, "a_branch_done");
      step(0, LUBR, O_STL, 1, 1, "a_lu_and_br");
      step(0, IDLE, O_NORM, 2, 1, "a_lu_br_done");
      step(0, BUSY, O_FRZ, 2, 1, "a_freeze");
      step(0, IDLE, O_NORM, 3, 1, "a_freeze_done");
      step(0, mk(0, 0, 9, 1, 9, 1, 0, 0, 0), O_STL, 3, 1, "a_lu_rt");
      step(0, IDLE, O_NORM, 4, 1, "a_lu_rt_done");
      step(0, mk(0, 5, 0, 0, 5, 0, 0, 0, 0), O_NORM, 4, 1, "a_no_load");

      // Instance B: LOAD_STALLS=3, BRANCH_FLUSH=2, CNT_W=4
      step(1, RSTV, O_RST, -1, -1, "b_rst0");
      step(1, RSTV, O_RST, 0, 0, "b_rst1");
      step(1, IDLE, O_NORM, 0, 0, "b_after_rst");
      step(1, mk(0, 0, 7, 1, 7, 1, 0, 0, 0), O_STL, 0, 0, "b_lu_rt_s1");
      step(1, IDLE, O_STL, 1, 0, "b_lu_rt_s2");
      step(1, IDLE, O_STL, 2, 0, "b_lu_rt_s3");
      step(1, IDLE, O_NORM, 3, 0, "b_lu_rt_done");
      step(1, mk(0, 0, 7, 0, 7, 1, 0, 0, 0), O_NORM, 3, 0, "b_rt_unused");
      step(1, BRV, O_FLS, 3, 0, "b_br_f1");
      step(1, IDLE, O_FLS, 3, 1, "b_br_f2");
      step(1, IDLE, O_NORM, 3, 2, "b_br_done");
      step(1, BRV, O_FLS, 3, 2, "b_br2_f1");
      step(1, LUBR, O_FLS, 3, 3, "b_flush_ignores_lu");
      step(1, IDLE, O_NORM, 3, 4, "b_br2_done");
      step(1, LU5, O_STL, 3, 4, "b_lu_enter");
      step(1, BUSY, O_FRZ, 4, 4, "b_frz1");
      step(1, BUSY, O_FRZ, 5, 4, "b_frz2");
      step(1, BUSY, O_FRZ, 6, 4, "b_frz3");
      step(1, BUSY, O_FRZ, 7, 4, "b_frz4");
      step(1, IDLE, O_STL, 8, 4, "b_lu_rem2");
      step(1, IDLE, O_STL, 9, 4, "b_lu_rem1");
      step(1, IDLE, O_NORM, 10, 4, "b_lu_frz_done");
      for (int i = 0; i < 20; i++) begin
         step(1, BUSY, O_FRZ, (10 + i > 15) ? 15 : 10 + i, 4, "b_sat");
      end
      step(1, IDLE, O_NORM, 15, 4, "b_sat_hold");
      step(1, mk(0, 5, 0, 0, 5, 1, 0, 0, 1), O_STL, 15, 4, "b_clr_in_stall");
      step(1, IDLE, O_STL, 0, 0, "b_cleared");
      step(1, IDLE, O_STL, 1, 0, "b_clr_s3");
      step(1, IDLE, O_NORM, 2, 0, "b_clr_done");
      step(1, BRV, O_FLS, 2, 0, "b_pre_rst_flush");
      step(1, RSTV, O_RST, 2, 1, "b_rst_mid_flush0");
      step(1, RSTV, O_RST, 0, 0, "b_rst_mid_flush1");
      step(1, IDLE, O_NORM, 0, 0, "b_flush_aborted");
      step(1, LU5, O_STL, 0, 0, "b_pre_rst_stall");
      step(1, RSTV, O_RST, 1, 0, "b_rst_mid_stall0");
      step(1, RSTV, O_RST, 0, 0, "b_rst_mid_stall1");
      step(1, IDLE, O_NORM, 0, 0, "b_stall_aborted");

      @(posedge clk);
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline stall/flush sequencer for the 5-stage MIPS core; sits beside the forwarding unit in the EX-stage control path.
- Detects load-use hazards the forwarding paths cannot cover, sequences branch/jump flushes, and freezes the pipeline while data memory is busy.
- Drives PC / IF-ID write enables, IF-ID flush, ID-EX bubble insertion and EX-MEM hold.
- Keeps saturating stall and flush performance counters.

Parameters:
- LOAD_STALLS, 1, bubble cycles inserted per load-use hazard (legal 1..7).
- BRANCH_FLUSH, 1, cycles IF-ID is flushed per taken branch/jump (legal 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Rs_IF_ID  in  5  Rs of the instruction in ID.
- Rt_IF_ID  in  5  Rt of the instruction in ID.
- Uses_Rt_ID  in  1  ID instruction reads Rt as a source.
- Rt_ID_EX  in  5  destination of the instruction in EX.
- MemRead_ID_EX  in  1  EX instruction is a load.
- Branch_Taken_ID  in  1  branch/jump resolved taken in ID.
- mem_busy  in  1  data memory not ready this cycle.
- perf_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF-ID register load enable.
- if_id_flush  out  1  IF-ID loads NOP.
- id_ex_bubble  out  1  ID-EX loads zeroed control (bubble).
- ex_mem_hold  out  1  EX-MEM and MEM-WB hold contents.
- stall_cnt  out  CNT_W  cycles with pc_write=0 outside reset.
- flush_cnt  out  CNT_W  cycles with if_id_flush=1 outside reset.

Behaviour:
- Outputs are combinational (Mealy) from state and inputs. State, remaining-count and counters are registered.
- States:
  - RUN: normal operation.
  - LU_STALL: extra load-use bubbles.
  - FLUSH: extra branch flush cycles.
- Remaining-count register rem is 3 bits.
- While rst=1:
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
  - Next state RUN, rem=0, both counters 0.
  - Reset mid-stall or mid-flush aborts the sequence.
- Freeze (highest priority): mem_busy=1 in any state gives pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=1. State and rem hold; hazards and branches are not evaluated.
- Load-use hazard (lu) is asserted when all hold:
  - MemRead_ID_EX=1.
  - Rt_ID_EX != 0.
  - Rt_ID_EX==Rs_IF_ID, or (Uses_Rt_ID=1 and Rt_ID_EX==Rt_IF_ID).
- RUN, no freeze, in priority order:
  - lu=1: pc_write=0, if_id_write=0, id_ex_bubble=1. Branch_Taken_ID is ignored because the ID instruction is not advancing. If LOAD_STALLS>1: go to LU_STALL, rem=LOAD_STALLS-1.
  - Otherwise Branch_Taken_ID=1: pc_write=1, if_id_write=1, if_id_flush=1. If BRANCH_FLUSH>1: go to FLUSH, rem=BRANCH_FLUSH-1.
  - Otherwise: pc_write=1, if_id_write=1, all others 0.
- LU_STALL, no freeze:
  - Same outputs as lu in RUN. Hazard inputs are not re-evaluated.
  - rem decrements; when rem==1 the next state is RUN.
- FLUSH, no freeze:
  - pc_write=1, if_id_write=1, if_id_flush=1.
  - Branch_Taken_ID and lu are ignored (ID holds a NOP).
  - rem decrements; when rem==1 the next state is RUN.
- Exactly one of the following holds in every non-reset cycle:
  - freeze.
  - stall (pc_write=0 and id_ex_bubble=1).
  - flush.
  - normal.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_write=0; freeze cycles count.
  - flush_cnt increments on every cycle with if_id_flush=1 and rst=0.
  - Both saturate at all-ones.
  - perf_clr=1 clears both to 0 next edge and overrides any increment that cycle.
- Counters update one cycle after the event: the value is visible after the clock edge.

Test Plan:
- Reset: hold rst 2 cycles mid-activity -> pc_write=0, if_id_flush=1, id_ex_bubble=1; after release, state RUN, stall_cnt=flush_cnt=0.
- Load-use with LOAD_STALLS=1: MemRead_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle normal; stall_cnt=1. Repeat with Rt_ID_EX=0 -> no stall.
- Load-use with LOAD_STALLS=3: Rt_IF_ID=7 match, Uses_Rt_ID=1 -> exactly 3 consecutive stall cycles, stall_cnt=3. Same match with Uses_Rt_ID=0 -> no stall.
- Branch with BRANCH_FLUSH=2: Branch_Taken_ID=1 one cycle -> if_id_flush=1 for 2 cycles, pc_write=1 throughout; flush_cnt=2.
- Simultaneous events:
  - lu and Branch_Taken_ID together -> stall only, flush_cnt unchanged.
  - mem_busy=1 for 4 cycles in LU_STALL with rem=2 -> ex_mem_hold=1 for 4 cycles, then 2 remaining stall cycles; stall_cnt +6.
- Counter saturation: CNT_W=4, force 20 stall cycles -> stall_cnt=15. Then perf_clr=1 during a stall -> stall_cnt=0.
